// File: rtl/matmul_sequencer.sv
// Tile sequencer for the systolic matmul datapath: walks N tiles through
// FILL -> DRAIN -> COMPUTE -> NEXT, optionally prefetching the next weight tile.
module matmul_sequencer #(
    parameter int WIDTH_HEIGHT = 16,
    parameter int ADDR_W       = 8,
    parameter int TILE_W       = 8,
    parameter int TIMEOUT_W    = 16
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           start,
    input  logic                           abort,
    input  logic [TILE_W-1:0]              cfg_num_tiles,
    input  logic                           cfg_prefetch,
    input  logic [ADDR_W-1:0]              cfg_in_base,
    input  logic [ADDR_W-1:0]              cfg_w_base,
    input  logic [ADDR_W-1:0]              cfg_out_base,
    input  logic [ADDR_W-1:0]              cfg_in_stride,
    input  logic [ADDR_W-1:0]              cfg_w_stride,
    input  logic [ADDR_W-1:0]              cfg_out_stride,
    input  logic                           mem_to_fifo_done,
    input  logic                           fifo_to_arr_done,
    input  logic                           output_done,
    output logic                           fill_fifo,
    output logic                           drain_fifo,
    output logic                           active,
    output logic [WIDTH_HEIGHT*ADDR_W-1:0] inputMem_rd_addr_base,
    output logic [WIDTH_HEIGHT*ADDR_W-1:0] weightMem_rd_addr_base,
    output logic [WIDTH_HEIGHT*ADDR_W-1:0] outputMem_wr_addr_base,
    output logic                           busy,
    output logic                           done,
    output logic                           error,
    output logic [TILE_W-1:0]              tile_idx,
    output logic [2:0]                     fsm_state
);

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_FILL    = 3'd1;
    localparam logic [2:0] S_DRAIN   = 3'd2;
    localparam logic [2:0] S_COMPUTE = 3'd3;
    localparam logic [2:0] S_NEXT    = 3'd4;
    localparam logic [2:0] S_FINISH  = 3'd5;

    localparam logic [TIMEOUT_W-1:0] WD_MAX = '1;

    logic [2:0]           state, state_n;
    logic [TILE_W-1:0]    num_tiles_q;
    logic                 prefetch_q;
    logic [ADDR_W-1:0]    in_stride_q, w_stride_q, out_stride_q;
    logic [ADDR_W-1:0]    in_addr, w_addr, out_addr;
    logic [ADDR_W-1:0]    in_addr_n, w_addr_n, out_addr_n;
    logic [TILE_W-1:0]    tile_n;
    logic [TIMEOUT_W-1:0] wd_cnt, wd_n;
    logic                 out_seen, out_seen_n;
    logic                 pf_pending, pf_pending_n;
    logic                 pf_issued, pf_issued_n;
    logic                 fill_n, drain_n, active_n, done_n, error_n;

    // Handshake: a strobe is high only in the entry cycle of its state; the
    // matching done input is honoured only in later cycles of that state, so a
    // done level left over from the previous request cannot complete the new one.
    logic fill_hit, drain_hit, out_hit, pf_hit, compute_ok, hs_done;

    assign fill_hit   = ~fill_fifo & mem_to_fifo_done;
    assign drain_hit  = ~drain_fifo & fifo_to_arr_done;
    assign out_hit    = ~active & output_done;
    assign pf_hit     = pf_pending & fill_hit;
    assign compute_ok = (out_seen | out_hit) & (~pf_pending | pf_hit);
    assign hs_done    = (state == S_FILL)  ? fill_hit :
                        (state == S_DRAIN) ? drain_hit : compute_ok;

    always_comb begin
        state_n      = state;
        fill_n       = 1'b0;
        drain_n      = 1'b0;
        active_n     = 1'b0;
        done_n       = 1'b0;
        error_n      = error;
        wd_n         = wd_cnt;
        out_seen_n   = out_seen;
        pf_pending_n = pf_pending;
        pf_issued_n  = pf_issued;
        tile_n       = tile_idx;
        in_addr_n    = in_addr;
        w_addr_n     = w_addr;
        out_addr_n   = out_addr;
        if (state != S_IDLE && abort) begin
            state_n      = S_IDLE;
            wd_n         = '0;
            out_seen_n   = 1'b0;
            pf_pending_n = 1'b0;
            pf_issued_n  = 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        in_addr_n    = cfg_in_base;
                        w_addr_n     = cfg_w_base;
                        out_addr_n   = cfg_out_base;
                        tile_n       = '0;
                        error_n      = 1'b0;
                        wd_n         = '0;
                        out_seen_n   = 1'b0;
                        pf_pending_n = 1'b0;
                        pf_issued_n  = 1'b0;
                        if (cfg_num_tiles == '0) begin
                            state_n = S_FINISH;
                            done_n  = 1'b1;
                        end else begin
                            state_n = S_FILL;
                            fill_n  = 1'b1;
                        end
                    end
                end
                S_FILL, S_DRAIN, S_COMPUTE: begin
                    if (wd_cnt == WD_MAX) begin
                        state_n      = S_IDLE;
                        out_seen_n   = 1'b0;
                        pf_pending_n = 1'b0;
                        pf_issued_n  = 1'b0;
                    end else if (hs_done) begin
                        wd_n = '0;
                        if (state == S_FILL) begin
                            state_n = S_DRAIN;
                            drain_n = 1'b1;
                        end else if (state == S_DRAIN) begin
                            state_n    = S_COMPUTE;
                            active_n   = 1'b1;
                            out_seen_n = 1'b0;
                            // Prefetch the next weight tile while this one computes.
                            if (prefetch_q && (tile_idx < num_tiles_q - TILE_W'(1))) begin
                                fill_n       = 1'b1;
                                w_addr_n     = w_addr + w_stride_q;
                                pf_pending_n = 1'b1;
                                pf_issued_n  = 1'b1;
                            end else begin
                                pf_pending_n = 1'b0;
                                pf_issued_n  = 1'b0;
                            end
                        end else begin
                            state_n      = S_NEXT;
                            out_seen_n   = 1'b0;
                            pf_pending_n = 1'b0;
                            tile_n       = tile_idx + TILE_W'(1);
                            in_addr_n    = in_addr + in_stride_q;
                            out_addr_n   = out_addr + out_stride_q;
                            if (!pf_issued) begin
                                w_addr_n = w_addr + w_stride_q;
                            end
                        end
                    end else begin
                        wd_n = wd_cnt + TIMEOUT_W'(1);
                        if (wd_cnt == WD_MAX - TIMEOUT_W'(1)) begin
                            error_n = 1'b1;
                        end
                        if (state == S_COMPUTE) begin
                            out_seen_n   = out_seen | out_hit;
                            pf_pending_n = pf_pending & ~pf_hit;
                        end
                    end
                end
                S_NEXT: begin
                    pf_issued_n = 1'b0;
                    wd_n        = '0;
                    // tile_idx already counts the completed tile here.
                    if (tile_idx == num_tiles_q) begin
                        state_n = S_FINISH;
                        done_n  = 1'b1;
                    end else if (pf_issued) begin
                        state_n = S_DRAIN;
                        drain_n = 1'b1;
                    end else begin
                        state_n = S_FILL;
                        fill_n  = 1'b1;
                    end
                end
                S_FINISH: state_n = S_IDLE;
                default:  state_n = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= S_IDLE;
            fill_fifo  <= 1'b0;
            drain_fifo <= 1'b0;
            active     <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            error      <= 1'b0;
            tile_idx   <= '0;
            in_addr    <= '0;
            w_addr     <= '0;
            out_addr   <= '0;
            wd_cnt     <= '0;
            out_seen   <= 1'b0;
            pf_pending <= 1'b0;
            pf_issued  <= 1'b0;
        end else begin
            state      <= state_n;
            fill_fifo  <= fill_n;
            drain_fifo <= drain_n;
            active     <= active_n;
            busy       <= (state_n != S_IDLE);
            done       <= done_n;
            error      <= error_n;
            tile_idx   <= tile_n;
            in_addr    <= in_addr_n;
            w_addr     <= w_addr_n;
            out_addr   <= out_addr_n;
            wd_cnt     <= wd_n;
            out_seen   <= out_seen_n;
            pf_pending <= pf_pending_n;
            pf_issued  <= pf_issued_n;
        end
    end

    // Job configuration is frozen at the accepted start.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            num_tiles_q  <= '0;
            prefetch_q   <= 1'b0;
            in_stride_q  <= '0;
            w_stride_q   <= '0;
            out_stride_q <= '0;
        end else if (state == S_IDLE && start) begin
            num_tiles_q  <= cfg_num_tiles;
            prefetch_q   <= cfg_prefetch;
            in_stride_q  <= cfg_in_stride;
            w_stride_q   <= cfg_w_stride;
            out_stride_q <= cfg_out_stride;
        end
    end

    assign inputMem_rd_addr_base  = {WIDTH_HEIGHT{in_addr}};
    assign weightMem_rd_addr_base = {WIDTH_HEIGHT{w_addr}};
    assign outputMem_wr_addr_base = {WIDTH_HEIGHT{out_addr}};
    assign fsm_state              = state;

endmodule

// File: tb/tb_matmul_sequencer.sv
// Bench for matmul_sequencer: directed jobs, a responder model for the datapath
// done flags, and an event scoreboard fed from the strobe/done/error outputs.
module tb_matmul_sequencer;

    localparam int WH  = 16;
    localparam int AW  = 8;
    localparam int TW  = 8;
    localparam int TOW = 4;
    localparam int EW  = 5 + TW + 3 * AW;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic start = 1'b0;
    logic abort = 1'b0;
    logic [TW-1:0] cfg_num_tiles = '0;
    logic cfg_prefetch = 1'b0;
    logic [AW-1:0] cfg_in_base = '0, cfg_w_base = '0, cfg_out_base = '0;
    logic [AW-1:0] cfg_in_stride = '0, cfg_w_stride = '0, cfg_out_stride = '0;
    logic mem_to_fifo_done = 1'b0, fifo_to_arr_done = 1'b0, output_done = 1'b0;
    logic fill_fifo, drain_fifo, active, busy, done, error;
    logic [WH*AW-1:0] in_bus, w_bus, out_bus;
    logic [TW-1:0] tile_idx;
    logic [2:0] fsm_state;

    int n_tests = 0;
    int n_fail = 0;
    logic [EW-1:0] exp_q[$];

    int fill_delay = 5;
    int drain_delay = 5;
    int act_delay = 5;
    logic drain_en = 1'b1;

    always #5 clk = ~clk;

    matmul_sequencer #(
        .WIDTH_HEIGHT(WH), .ADDR_W(AW), .TILE_W(TW), .TIMEOUT_W(TOW)
    ) dut (
        .clk(clk), .reset(rst_n), .start(start), .abort(abort),
        .cfg_num_tiles(cfg_num_tiles), .cfg_prefetch(cfg_prefetch),
        .cfg_in_base(cfg_in_base), .cfg_w_base(cfg_w_base), .cfg_out_base(cfg_out_base),
        .cfg_in_stride(cfg_in_stride), .cfg_w_stride(cfg_w_stride), .cfg_out_stride(cfg_out_stride),
        .mem_to_fifo_done(mem_to_fifo_done), .fifo_to_arr_done(fifo_to_arr_done),
        .output_done(output_done),
        .fill_fifo(fill_fifo), .drain_fifo(drain_fifo), .active(active),
        .inputMem_rd_addr_base(in_bus), .weightMem_rd_addr_base(w_bus),
        .outputMem_wr_addr_base(out_bus),
        .busy(busy), .done(done), .error(error), .tile_idx(tile_idx), .fsm_state(fsm_state)
    );

    function automatic logic [EW-1:0] ev(input logic f, input logic d, input logic a,
                                         input logic dn, input logic er, input logic [TW-1:0] t,
                                         input logic [AW-1:0] w, input logic [AW-1:0] ib,
                                         input logic [AW-1:0] ob);
        return {f, d, a, dn, er, t, w, ib, ob};
    endfunction

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] req);
        n_tests++;
        if (got !== req) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, got, req);
        end
    endtask

    // Datapath model: each done flag pulses for one cycle, a fixed delay after its strobe.
    initial begin : responder
        int fc, dc, ac;
        fc = 0; dc = 0; ac = 0;
        forever begin
            @(negedge clk);
            mem_to_fifo_done = 1'b0;
            fifo_to_arr_done = 1'b0;
            output_done      = 1'b0;
            if (!rst_n) begin
                fc = 0; dc = 0; ac = 0;
            end else begin
                if (fc > 0) begin fc--; if (fc == 0) mem_to_fifo_done = 1'b1; end
                if (dc > 0) begin dc--; if (dc == 0) fifo_to_arr_done = 1'b1; end
                if (ac > 0) begin ac--; if (ac == 0) output_done = 1'b1; end
                if (fill_fifo) fc = fill_delay;
                if (drain_fifo && drain_en) dc = drain_delay;
                if (active) ac = act_delay;
            end
        end
    end

    // Monitor: every strobe, done pulse or error rise is popped against the expected queue.
    logic err_prev = 1'b0;
    always @(negedge clk) begin : monitor
        logic [EW-1:0] got, want;
        if (!rst_n) begin
            err_prev = 1'b0;
        end else begin
            if (fill_fifo || drain_fifo || active || done || (error && !err_prev)) begin
                got = ev(fill_fifo, drain_fifo, active, done, error & ~err_prev, tile_idx,
                         w_bus[AW-1:0], in_bus[AW-1:0], out_bus[AW-1:0]);
                n_tests++;
                if (exp_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL unexpected_event: got %h, expected none", got);
                end else begin
                    want = exp_q.pop_front();
                    if (got !== want) begin
                        n_fail++;
                        $display("FAIL event: got %h, expected %h", got, want);
                    end
                end
                n_tests++;
                if (in_bus !== {WH{in_bus[AW-1:0]}} || w_bus !== {WH{w_bus[AW-1:0]}} ||
                    out_bus !== {WH{out_bus[AW-1:0]}}) begin
                    n_fail++;
                    $display("FAIL lane_rep: got w=%h, expected all lanes equal", w_bus);
                end
            end
            err_prev = error;
        end
    end

    task automatic start_job(input logic [TW-1:0] n, input logic pf,
                             input logic [AW-1:0] ib, input logic [AW-1:0] wb,
                             input logic [AW-1:0] ob, input logic [AW-1:0] is,
                             input logic [AW-1:0] ws, input logic [AW-1:0] os);
        @(negedge clk);
        cfg_num_tiles = n; cfg_prefetch = pf;
        cfg_in_base = ib; cfg_w_base = wb; cfg_out_base = ob;
        cfg_in_stride = is; cfg_w_stride = ws; cfg_out_stride = os;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("start_busy", 64'(busy), 64'd1);
        check("start_fill", 64'(fill_fifo), 64'(n != 0));
        check("start_error_clear", 64'(error), 64'd0);
    endtask

    task automatic wait_idle(input string name, input int max);
        int k;
        k = 0;
        while (busy && k < max) begin @(negedge clk); k++; end
        check({name, "_idle"}, 64'(busy), 64'd0);
    endtask

    initial begin : global_timeout
        #500000;
        $display("FAIL global_timeout: got no finish, expected finish");
        $fatal(1);
    end

    initial begin : main
        int k;
        #12;
        check("reset_strobes", 64'({fill_fifo, drain_fifo, active}), 64'd0);
        check("reset_status", 64'({busy, done, error}), 64'd0);
        check("reset_tile_state", 64'({tile_idx, fsm_state}), 64'd0);
        check("reset_addr", 64'(|{in_bus, w_bus, out_bus}), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Single tile, zero strides: buses stay at the bases.
        exp_q.push_back(ev(1, 0, 0, 0, 0, 0, 8'h20, 8'h10, 8'h30));
        exp_q.push_back(ev(0, 1, 0, 0, 0, 0, 8'h20, 8'h10, 8'h30));
        exp_q.push_back(ev(0, 0, 1, 0, 0, 0, 8'h20, 8'h10, 8'h30));
        exp_q.push_back(ev(0, 0, 0, 1, 0, 1, 8'h20, 8'h10, 8'h30));
        start_job(1, 0, 8'h10, 8'h20, 8'h30, 8'h00, 8'h00, 8'h00);
        wait_idle("single", 100);
        check("single_queue", 64'(exp_q.size()), 64'd0);
        check("single_wbus", 64'(w_bus[AW-1:0]), 64'h20);

        // Stride and wrap, plus a start/cfg change while busy that must be ignored.
        exp_q.push_back(ev(1, 0, 0, 0, 0, 0, 8'hF0, 8'h00, 8'hFE));
        exp_q.push_back(ev(0, 1, 0, 0, 0, 0, 8'hF0, 8'h00, 8'hFE));
        exp_q.push_back(ev(0, 0, 1, 0, 0, 0, 8'hF0, 8'h00, 8'hFE));
        exp_q.push_back(ev(1, 0, 0, 0, 0, 1, 8'h00, 8'h04, 8'hFF));
        exp_q.push_back(ev(0, 1, 0, 0, 0, 1, 8'h00, 8'h04, 8'hFF));
        exp_q.push_back(ev(0, 0, 1, 0, 0, 1, 8'h00, 8'h04, 8'hFF));
        exp_q.push_back(ev(1, 0, 0, 0, 0, 2, 8'h10, 8'h08, 8'h00));
        exp_q.push_back(ev(0, 1, 0, 0, 0, 2, 8'h10, 8'h08, 8'h00));
        exp_q.push_back(ev(0, 0, 1, 0, 0, 2, 8'h10, 8'h08, 8'h00));
        exp_q.push_back(ev(0, 0, 0, 1, 0, 3, 8'h20, 8'h0C, 8'h01));
        start_job(3, 0, 8'h00, 8'hF0, 8'hFE, 8'h04, 8'h10, 8'h01);
        k = 0;
        while (!active && k < 50) begin @(negedge clk); k++; end
        check("stride_see_active", 64'(active), 64'd1);
        cfg_num_tiles = 1; cfg_w_base = 8'h77; cfg_w_stride = 8'h01; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_idle("stride", 200);
        check("stride_queue", 64'(exp_q.size()), 64'd0);

        // Prefetch: fill rides with active on tiles 0 and 1, later fills skipped.
        fill_delay = 7; act_delay = 3;
        exp_q.push_back(ev(1, 0, 0, 0, 0, 0, 8'h40, 8'h80, 8'h00));
        exp_q.push_back(ev(0, 1, 0, 0, 0, 0, 8'h40, 8'h80, 8'h00));
        exp_q.push_back(ev(1, 0, 1, 0, 0, 0, 8'h48, 8'h80, 8'h00));
        exp_q.push_back(ev(0, 1, 0, 0, 0, 1, 8'h48, 8'h82, 8'h01));
        exp_q.push_back(ev(1, 0, 1, 0, 0, 1, 8'h50, 8'h82, 8'h01));
        exp_q.push_back(ev(0, 1, 0, 0, 0, 2, 8'h50, 8'h84, 8'h02));
        exp_q.push_back(ev(0, 0, 1, 0, 0, 2, 8'h50, 8'h84, 8'h02));
        exp_q.push_back(ev(0, 0, 0, 1, 0, 3, 8'h58, 8'h86, 8'h03));
        start_job(3, 1, 8'h80, 8'h40, 8'h00, 8'h02, 8'h08, 8'h01);
        wait_idle("prefetch", 200);
        check("prefetch_queue", 64'(exp_q.size()), 64'd0);
        fill_delay = 5; act_delay = 5;

        // Watchdog: drain never completes.
        drain_en = 1'b0;
        exp_q.push_back(ev(1, 0, 0, 0, 0, 0, 8'h02, 8'h01, 8'h03));
        exp_q.push_back(ev(0, 1, 0, 0, 0, 0, 8'h02, 8'h01, 8'h03));
        exp_q.push_back(ev(0, 0, 0, 0, 1, 0, 8'h02, 8'h01, 8'h03));
        start_job(2, 0, 8'h01, 8'h02, 8'h03, 8'h01, 8'h01, 8'h01);
        k = 0;
        while (!drain_fifo && k < 50) begin @(negedge clk); k++; end
        check("wd_see_drain", 64'(drain_fifo), 64'd1);
        k = 0;
        while (!error && k < 40) begin @(negedge clk); k++; end
        check("wd_latency", 64'(k), 64'd15);
        @(negedge clk);
        check("wd_busy_after", 64'(busy), 64'd0);
        repeat (3) @(negedge clk);
        check("wd_error_sticky", 64'(error), 64'd1);
        check("wd_queue", 64'(exp_q.size()), 64'd0);
        drain_en = 1'b1;

        // Abort in COMPUTE of tile 1, then an immediate empty job.
        act_delay = 8;
        exp_q.push_back(ev(1, 0, 0, 0, 0, 0, 8'h02, 8'h01, 8'h03));
        exp_q.push_back(ev(0, 1, 0, 0, 0, 0, 8'h02, 8'h01, 8'h03));
        exp_q.push_back(ev(0, 0, 1, 0, 0, 0, 8'h02, 8'h01, 8'h03));
        exp_q.push_back(ev(1, 0, 0, 0, 0, 1, 8'h03, 8'h02, 8'h04));
        exp_q.push_back(ev(0, 1, 0, 0, 0, 1, 8'h03, 8'h02, 8'h04));
        exp_q.push_back(ev(0, 0, 1, 0, 0, 1, 8'h03, 8'h02, 8'h04));
        start_job(3, 0, 8'h01, 8'h02, 8'h03, 8'h01, 8'h01, 8'h01);
        k = 0;
        while (!(active && tile_idx == 1) && k < 100) begin @(negedge clk); k++; end
        check("abort_see_tile1", 64'(active && tile_idx == 1), 64'd1);
        @(negedge clk);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        check("abort_idle", 64'({busy, fsm_state}), 64'd0);
        check("abort_quiet", 64'({fill_fifo, drain_fifo, active, done, error}), 64'd0);
        exp_q.push_back(ev(0, 0, 0, 1, 0, 0, 8'hB0, 8'hA0, 8'hC0));
        start_job(0, 0, 8'hA0, 8'hB0, 8'hC0, 8'h01, 8'h01, 8'h01);
        check("empty_done", 64'(done), 64'd1);
        @(negedge clk);
        check("empty_after", 64'({done, busy}), 64'd0);
        check("abort_queue", 64'(exp_q.size()), 64'd0);
        repeat (12) @(negedge clk);
        act_delay = 5;

        // Asynchronous reset in DRAIN, then a fresh job.
        exp_q.push_back(ev(1, 0, 0, 0, 0, 0, 8'h22, 8'h11, 8'h33));
        exp_q.push_back(ev(0, 1, 0, 0, 0, 0, 8'h22, 8'h11, 8'h33));
        start_job(1, 0, 8'h11, 8'h22, 8'h33, 8'h00, 8'h00, 8'h00);
        k = 0;
        while (!drain_fifo && k < 50) begin @(negedge clk); k++; end
        check("rst_see_drain", 64'(drain_fifo), 64'd1);
        #2 rst_n = 1'b0;
        #1;
        check("rst_async_strobes", 64'({fill_fifo, drain_fifo, active}), 64'd0);
        check("rst_async_status", 64'({busy, done, error, tile_idx, fsm_state}), 64'd0);
        check("rst_async_addr", 64'(|{in_bus, w_bus, out_bus}), 64'd0);
        check("rst_queue", 64'(exp_q.size()), 64'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        exp_q.push_back(ev(1, 0, 0, 0, 0, 0, 8'h55, 8'h44, 8'h66));
        exp_q.push_back(ev(0, 1, 0, 0, 0, 0, 8'h55, 8'h44, 8'h66));
        exp_q.push_back(ev(0, 0, 1, 0, 0, 0, 8'h55, 8'h44, 8'h66));
        exp_q.push_back(ev(0, 0, 0, 1, 0, 1, 8'h55, 8'h44, 8'h66));
        start_job(1, 0, 8'h44, 8'h55, 8'h66, 8'h00, 8'h00, 8'h00);
        wait_idle("post_reset", 100);
        check("post_reset_queue", 64'(exp_q.size()), 64'd0);

        repeat (2) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
